// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory req/ack side plus decoder valid/ready and redirect side.
// master = fetch_unit, slave = memory/decoder environment; fetch_misaligned exists only with FETCH_MISALIGN_TRAP_EN.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ip_imem_ack;
    logic [31:0] ip_imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        ip_inst_ready;
    logic        ip_redirect;
    logic [31:0] ip_redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  ip_imem_ack, ip_imem_rdata, ip_inst_ready, ip_redirect, ip_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
        , output fetch_misaligned
`endif
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output ip_imem_ack, ip_imem_rdata, ip_inst_ready, ip_redirect, ip_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
        , input fetch_misaligned
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem req/ack, registered inst with valid/ready to decoder.
// Latency: word presented the cycle after ack; one instruction per 2 cycles with combinational ack.
// Backpressure: HOLD keeps inst stable and stops fetching until ready; FETCH_MISALIGN_TRAP_EN adds FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         ip_clk,
    input  logic         ip_reset_n,
    fetch_unit_if.master bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [31:0] inst_pc_q, inst_pc_nxt;
    logic        inst_vld_q, inst_vld_nxt;
    logic [31:0] target;
    logic        tgt_ok;
    logic        pc_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam state_t MIS_ST = FAULT;
    assign target = bus.ip_redirect_pc;
    assign tgt_ok = (target[1:0] == 2'b00);
    assign pc_ok  = (pc[1:0] == 2'b00);
    assign bus.fetch_misaligned = (state == FAULT);
`else
    // Without the trap a misaligned target is silently rounded down to its word.
    localparam state_t MIS_ST = REQ;
    assign target = bus.ip_redirect_pc & 32'hFFFF_FFFC;
    assign tgt_ok = 1'b1;
    assign pc_ok  = 1'b1;
`endif

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        inst_nxt       = inst_q;
        inst_pc_nxt    = inst_pc_q;
        inst_vld_nxt   = inst_vld_q;
        case (state)
            IDLE: begin
                if (bus.ip_redirect) begin
                    pc_nxt    = target;
                    state_nxt = tgt_ok ? REQ : MIS_ST;
                end else begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.ip_redirect) begin
                    pc_nxt = target;
                    if (bus.ip_imem_ack) begin
                        state_nxt = tgt_ok ? REQ : MIS_ST;
                    end else begin
                        // Address must stay put until the memory answers.
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end else if (bus.ip_imem_ack) begin
                    inst_nxt     = bus.ip_imem_rdata;
                    inst_pc_nxt  = pc;
                    pc_nxt       = pc + 32'd4;
                    inst_vld_nxt = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (bus.ip_redirect) begin
                    inst_vld_nxt = 1'b0;
                    pc_nxt       = target;
                    state_nxt    = tgt_ok ? REQ : MIS_ST;
                end else if (bus.ip_inst_ready) begin
                    inst_vld_nxt = 1'b0;
                    state_nxt    = REQ;
                end
            end
            DRAIN: begin
                if (bus.ip_redirect) begin
                    pc_nxt = target;
                end
                if (bus.ip_imem_ack) begin
                    if (bus.ip_redirect) begin
                        state_nxt = tgt_ok ? REQ : MIS_ST;
                    end else begin
                        state_nxt = pc_ok ? REQ : MIS_ST;
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                if (bus.ip_redirect) begin
                    pc_nxt = target;
                    if (tgt_ok) begin
                        state_nxt = REQ;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ip_clk or negedge ip_reset_n) begin
        if (!ip_reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            inst_q     <= NOP;
            inst_pc_q  <= 32'h0000_0000;
            inst_vld_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            inst_q     <= inst_nxt;
            inst_pc_q  <= inst_pc_nxt;
            inst_vld_q <= inst_vld_nxt;
        end
    end

    assign bus.imem_req   = (state == REQ) || (state == DRAIN);
    assign bus.imem_addr  = ((state == DRAIN) ? drain_addr : pc) & 32'hFFFF_FFFC;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random memory/decoder/redirect traffic against a transaction model.
module tb_fetch_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .ip_clk    (clk),
        .ip_reset_n(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction model: next fetch address, next delivered pc, the request in flight.
    logic [31:0] exp_fetch, exp_deliver, out_addr;
    bit          out_active, out_stale, have_inst;
    int          deliveries;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic model_reset();
        exp_fetch   = 32'h0;
        exp_deliver = 32'h0;
        out_addr    = 32'h0;
        out_active  = 1'b0;
        out_stale   = 1'b0;
        have_inst   = 1'b0;
    endtask

    task automatic drive_quiet();
        bus.ip_imem_ack    = 1'b0;
        bus.ip_imem_rdata  = 32'h0;
        bus.ip_inst_ready  = 1'b0;
        bus.ip_redirect    = 1'b0;
        bus.ip_redirect_pc = 32'h0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req",   bus.imem_req,   32'h0);
        chk("rst_addr",  bus.imem_addr,  32'h0);
        chk("rst_inst",  bus.inst,       32'h0000_0013);
        chk("rst_pc",    bus.inst_pc,    32'h0);
        chk("rst_valid", bus.inst_valid, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misaligned", bus.fetch_misaligned, 32'h0);
`endif
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance the model, wait one cycle.
    task automatic cycle(input bit want_ack, input bit rdy, input bit redir, input logic [31:0] tgt);
        logic [31:0] tm;
        bit          ack;
        bit          faulted;
        faulted = (exp_fetch[1:0] != 2'b00);
        if (out_active) begin
            chk("req_hold",  bus.imem_req,  32'h1);
            chk("addr_hold", bus.imem_addr, out_addr);
        end else if (faulted) begin
            chk("fault_no_req", bus.imem_req, 32'h0);
        end else if (bus.imem_req) begin
            chk("req_addr", bus.imem_addr, exp_fetch);
        end
        chk("valid", bus.inst_valid, have_inst);
        if (have_inst) begin
            chk("inst_pc",     bus.inst_pc,  exp_deliver);
            chk("inst_word",   bus.inst,     mem_word(exp_deliver));
            chk("hold_no_req", bus.imem_req, 32'h0);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misaligned", bus.fetch_misaligned, faulted && !out_active);
`endif

        ack = want_ack && bus.imem_req;
        bus.ip_imem_ack    = ack;
        bus.ip_imem_rdata  = ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
        bus.ip_inst_ready  = rdy;
        bus.ip_redirect    = redir;
        bus.ip_redirect_pc = tgt;

        if (!out_active && bus.imem_req) begin
            out_active = 1'b1;
            out_addr   = bus.imem_addr;
            out_stale  = 1'b0;
        end
        if (redir) begin
            tm          = eff_target(tgt);
            exp_fetch   = tm;
            exp_deliver = tm;
            have_inst   = 1'b0;
            if (out_active) begin
                if (ack) out_active = 1'b0;
                else     out_stale  = 1'b1;
            end
        end else begin
            if (have_inst && rdy) begin
                have_inst   = 1'b0;
                exp_deliver = exp_deliver + 32'd4;
                deliveries++;
            end
            if (out_active && ack) begin
                out_active = 1'b0;
                if (!out_stale) begin
                    have_inst = 1'b1;
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic random_phase(input int n);
        logic [31:0] r;
        logic [31:0] tgt;
        int unsigned k;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0)      tgt = 32'hFFFF_FFF8;
            else if (k == 1) tgt = r;
            else             tgt = r & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, tgt);
        end
    endtask

    initial begin
        deliveries = 0;
        drive_quiet();
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: first fetch, combinational ack, ready high
        cycle(1, 1, 0, 32'h0);
        chk("t1_req",  bus.imem_req,  32'h1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        cycle(1, 1, 0, 32'h0);
        chk("t1_valid", bus.inst_valid, 32'h1);
        chk("t1_inst",  bus.inst,       32'h0010_0093);
        chk("t1_pc",    bus.inst_pc,    32'h0);
        cycle(1, 1, 0, 32'h0);
        chk("t1_next_addr", bus.imem_addr, 32'h4);

        // Test 2: decoder stalls five cycles in HOLD
        cycle(1, 0, 0, 32'h0);
        repeat (5) cycle(1, 0, 0, 32'h0);
        chk("t2_pc", bus.inst_pc, 32'h4);
        cycle(1, 1, 0, 32'h0);
        chk("t2_addr", bus.imem_addr, 32'h8);

        // Test 3: redirect while ack is delayed
        cycle(0, 0, 1, 32'h100);
        cycle(0, 0, 0, 32'h0);
        cycle(0, 0, 0, 32'h0);
        cycle(1, 0, 0, 32'h0);
        chk("t3_valid", bus.inst_valid, 32'h0);
        chk("t3_addr",  bus.imem_addr,  32'h100);

        // Test 4: redirect in HOLD with ready in the same cycle
        cycle(1, 0, 0, 32'h0);
        cycle(0, 1, 1, 32'h200);
        chk("t4_valid", bus.inst_valid, 32'h0);
        chk("t4_addr",  bus.imem_addr,  32'h200);

        // Test 5: two redirects while draining, latest wins
        cycle(0, 0, 1, 32'h300);
        cycle(0, 0, 1, 32'h400);
        chk("t5_drain_addr", bus.imem_addr, 32'h200);
        cycle(1, 0, 0, 32'h0);
        chk("t5_addr", bus.imem_addr, 32'h400);

        // Test 6: wrap past the top of the address space
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        chk("t6_valid", bus.inst_valid, 32'h0);
        cycle(1, 0, 0, 32'h0);
        chk("t6_pc", bus.inst_pc, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 32'h0);
        chk("t6_wrap_addr", bus.imem_addr, 32'h0);
        cycle(0, 0, 1, 32'h102);
        cycle(1, 0, 0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_fault_flag", bus.fetch_misaligned, 32'h1);
        chk("t6_fault_req",  bus.imem_req,         32'h0);
        repeat (3) cycle(1, 1, 0, 32'h0);
        cycle(0, 0, 1, 32'h104);
        chk("t6_clear_flag", bus.fetch_misaligned, 32'h0);
        chk("t6_clear_addr", bus.imem_addr,        32'h104);
`else
        chk("t6_round_addr", bus.imem_addr, 32'h100);
`endif

        random_phase(3000);

        // Reset in the middle of traffic must take effect immediately
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive_quiet();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        random_phase(1000);
        chk("progress", deliveries >= 100, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
